prog_loader: RTL
================

Name: prog_loader

Overview:
- Serial program loader that writes the core's 25-entry instruction memory through its write port: write enable, 5-bit address, 8-bit data.
- Receives a framed byte stream on a UART line and issues one single-cycle write per payload byte at sequential addresses starting from 0.
- Reports completion or error so board logic can release the core to run.
- Sits between the host serial pin and the core's write-enable/address/data inputs.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4 and even.
- MEM_DEPTH, 25, instruction memory entries; legal LEN range is 1..MEM_DEPTH.
- ADDR_W, 5, address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 65535, maximum clk cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  UART line; idle high; asynchronous to clk.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  8  write data.
- busy  out  1  high while a frame is in progress (state != IDLE).
- load_done  out  1  sticky; last frame loaded with a good checksum.
- load_err  out  1  sticky; last frame aborted or had a bad checksum.

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0, the FSM goes to IDLE, and all counters clear. Reset mid-frame discards the frame; memory already written is not restored.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK. CHK is valid when (sum of payload + CHK) mod 256 == 0.
- UART RX sub-block:
  - 2-flop synchronizer on rx.
  - A falling edge in idle starts reception. The start bit is re-checked at CLKS_PER_BIT/2; if high, it is a glitch and the receiver returns to idle.
  - 8 data bits, LSB first, each sampled at mid-bit. Then the stop bit.
  - Stop = 1: pulse byte_valid for 1 cycle with the byte.
  - Stop = 0: pulse frame_err for 1 cycle and emit no byte.
- Loader FSM:
  - IDLE: wait for byte_valid with SYNC_BYTE; other bytes and frame_err are ignored. On SYNC: clear load_done and load_err, clear the checksum accumulator, go to LEN.
  - LEN: if LEN is 0 or greater than MEM_DEPTH, set load_err and go to IDLE with no writes. Otherwise store LEN, set index to 0, go to DATA.
  - DATA: on each byte, in the next cycle mem_we=1, mem_addr=index, mem_data=byte. Add the byte to the accumulator and increment the index. After the LEN-th byte, go to CHK.
  - CHK: if (accumulator + byte) mod 256 == 0, set load_done; otherwise set load_err. Go to IDLE.
- In LEN, DATA or CHK:
  - A frame_err sets load_err and returns the FSM to IDLE.
  - Timeout: the inter-byte counter reaching TIMEOUT_CLKS with no byte sets load_err and returns to IDLE. The counter resets on every byte_valid.
- mem_we is never high for more than 1 consecutive cycle; mem_addr and mem_data hold their last value between writes.
- load_done and load_err are mutually exclusive.
- SYNC_BYTE received inside a frame is treated as data, with no resync.
- Accumulator is 8-bit and wraps modulo 256.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, LEN, DATA, CHK.
  - Default SYNC_BYTE and MEM_DEPTH constants, shared with the core's opcode package.
- One sub-module: prog_loader_uart_rx. Inputs: clk, rst, rx. Outputs: byte_valid, byte_data[7:0], frame_err. Parameter: CLKS_PER_BIT.

Test Plan:
- Good frame A5 03 01 2A 0A CB (CLKS_PER_BIT=16) -> 3 mem_we pulses: addr 0/1/2, data 01/2A/0A; load_done=1, load_err=0, busy=0 after CB.
- Same frame with CHK=00 -> 3 writes still occur; load_err=1, load_done=0.
- Bytes 55 FF then good frame -> 55 and FF are ignored, no writes; frame loads normally with load_done=1.
- LEN=1A (26) or LEN=00 -> load_err=1, zero mem_we pulses, FSM back in IDLE; a subsequent good frame succeeds.
- Stop bit driven 0 on 2nd payload byte -> exactly 1 write (addr 0); load_err=1, FSM in IDLE.
- rst=1 pulse after LEN byte, or line idle for TIMEOUT_CLKS after LEN -> rst case: all outputs 0; timeout case: load_err=1; both cases busy=0 and the next frame loads from addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encodings, frame
// constants shared with the core's opcode package, and the checksum helper.
package prog_loader_pkg;

    localparam int         MEM_DEPTH_DEF = 25;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Running 8-bit checksum; wraps modulo 256 so a good frame sums to zero.
    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: synchronises the line, validates the start bit at
// half-bit, samples data at mid-bit and reports either a byte or a framing error.
import prog_loader_pkg::*;

module prog_loader_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    rx_state_e        rx_state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Bit-timing state machine; byte_valid and frame_err are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r <= '0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        // A line already back high at mid start bit was only a glitch.
                        if (rx_sync_r) begin
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_state_r <= RX_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_state_r <= RX_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == FULL_M1) begin
                        cnt_r      <= '0;
                        rx_state_r <= RX_IDLE;
                        if (rx_sync_r) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_r;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    cnt_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/LEN/payload/CHK frames from the UART
// and writes the payload into instruction memory at addresses 0..LEN-1.
import prog_loader_pkg::*;

module prog_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         MEM_DEPTH    = MEM_DEPTH_DEF,
    parameter int         ADDR_W       = 5,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int            TO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    DEPTH_B = 8'(MEM_DEPTH);

    logic            byte_valid_s;
    logic [7:0]      byte_data_s;
    logic            frame_err_s;

    ld_state_e       state_r;
    logic [7:0]      len_r;
    logic [7:0]      idx_r;
    logic [7:0]      acc_r;
    logic [TO_W-1:0] to_cnt_r;

    prog_loader_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .frame_err  (frame_err_s)
    );

    // Frame-level FSM with registered memory-write and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            len_r     <= 8'd0;
            idx_r     <= 8'd0;
            acc_r     <= 8'd0;
            to_cnt_r  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= 8'd0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                IDLE: begin
                    to_cnt_r <= '0;
                    if (byte_valid_s && (byte_data_s == SYNC_BYTE)) begin
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        acc_r     <= 8'd0;
                        busy      <= 1'b1;
                        state_r   <= LEN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                LEN, DATA, CHK: begin
                    if (frame_err_s) begin
                        load_err  <= 1'b1;
                        load_done <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else if (byte_valid_s) begin
                        to_cnt_r <= '0;
                        case (state_r)
                            LEN: begin
                                if ((byte_data_s == 8'd0) || (byte_data_s > DEPTH_B)) begin
                                    load_err  <= 1'b1;
                                    load_done <= 1'b0;
                                    busy      <= 1'b0;
                                    state_r   <= IDLE;
                                end else begin
                                    len_r   <= byte_data_s;
                                    idx_r   <= 8'd0;
                                    state_r <= DATA;
                                end
                            end
                            DATA: begin
                                mem_we   <= 1'b1;
                                mem_addr <= idx_r[ADDR_W-1:0];
                                mem_data <= byte_data_s;
                                acc_r    <= chk_add(acc_r, byte_data_s);
                                idx_r    <= idx_r + 8'd1;
                                if (idx_r == (len_r - 8'd1)) begin
                                    state_r <= CHK;
                                end else begin
                                    state_r <= DATA;
                                end
                            end
                            CHK: begin
                                busy    <= 1'b0;
                                state_r <= IDLE;
                                if (chk_add(acc_r, byte_data_s) == 8'd0) begin
                                    load_done <= 1'b1;
                                    load_err  <= 1'b0;
                                end else begin
                                    load_done <= 1'b0;
                                    load_err  <= 1'b1;
                                end
                            end
                            default: begin
                                busy    <= 1'b0;
                                state_r <= IDLE;
                            end
                        endcase
                    end else if (to_cnt_r == TO_LAST) begin
                        // Host went silent mid-frame: abandon it.
                        load_err  <= 1'b1;
                        load_done <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
